// File: rtl/wm8731_i2c_init_if.sv
// wm8731_i2c_init_if
//   Status and clock lines of the WM8731 I2C configuration block.
//   The open-drain SDA line is not part of this bundle. It needs a real
//   tristate net, so it stays a plain inout port on the module.
//
//   i2c_sclk   SCL, push-pull, idle high
//   busy       high from reset release until the table is complete
//   done       table complete, held until the next reset
//   ack_error  sticky NACK flag
//   word_idx   index of the current or last table entry
//   state_dbg  raw FSM state, for debug and checker binding
interface wm8731_i2c_init_if;
  logic       i2c_sclk;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic [3:0] word_idx;
  logic [2:0] state_dbg;

  modport master (
    output i2c_sclk, busy, done, ack_error, word_idx, state_dbg
  );

  modport slave (
    input i2c_sclk, busy, done, ack_error, word_idx, state_dbg
  );
endinterface

// File: rtl/wm8731_i2c_init.sv
// wm8731_i2c_init
//   After reset, writes the fixed 10-entry WM8731 register table over I2C.
//   It then idles with done asserted. There is one bit engine, stepped on a
//   quarter-bit tick (qtick), plus a table sequencer.
//
//   Ports:
//     clk       system clock (CLOCK2_50)
//     reset     synchronous, active high; aborts any frame (no STOP is sent)
//     i2c_sdat  SDA, open drain: driven 0 or released (Z); sampled on the pin
//     bus       wm8731_i2c_init_if.master (SCL, busy, done, ack_error,
//               word_idx, state_dbg)
//
//   Optional feature macro: I2C_RETRY_EN
//     A NACK ends the frame with STOP+GAP, and the same entry is resent,
//     up to 3 retries. ack_error is set only when the 4th attempt also NACKs.
module wm8731_i2c_init #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          I2C_HZ     = 20000,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter logic [15:0] INIT_DELAY = 16'd1000
) (
  input  logic clk,
  input  logic reset,
  inout  wire  i2c_sdat,
  wm8731_i2c_init_if.master bus
);
  localparam int          QDIV      = CLK_HZ / (4 * I2C_HZ);
  localparam logic [15:0] QDIV_LAST = 16'(QDIV - 1);

  typedef enum logic [2:0] {
    S_WAIT, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE
  } state_t;

  // Each entry is {reg[6:0], data[8:0]}.
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    table_word = {7'd15, 9'h000};
      4'd1:    table_word = {7'd0,  9'h017};
      4'd2:    table_word = {7'd1,  9'h017};
      4'd3:    table_word = {7'd2,  9'h079};
      4'd4:    table_word = {7'd3,  9'h079};
      4'd5:    table_word = {7'd4,  9'h012};
      4'd6:    table_word = {7'd5,  9'h000};
      4'd7:    table_word = {7'd6,  9'h000};
      4'd8:    table_word = {7'd7,  9'h002};
      default: table_word = {7'd9,  9'h001};
    endcase
  endfunction

  logic [15:0] div_cnt;
  logic        qtick;
  state_t      state, state_n;
  logic [1:0]  phase, phase_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [1:0]  byte_idx, byte_n;
  logic [3:0]  word_idx, word_n;
  logic [15:0] wait_cnt, wait_n;
  logic        sclk_q, sclk_n;
  logic        sda_low_q, sda_low_n;
  logic        ack_error_q, ack_err_n;
  logic [1:0]  sda_sync;
  logic [15:0] cur_word;
  logic [7:0]  cur_byte;
`ifdef I2C_RETRY_EN
  logic        nack_q, nack_n;
  logic [1:0]  retry_cnt, retry_n;
`endif

  // Quarter-bit tick divider.
  assign qtick = (div_cnt == QDIV_LAST);

  always_ff @(posedge clk) begin
    if (reset || qtick) div_cnt <= 16'd0;
    else                div_cnt <= div_cnt + 16'd1;
  end

  // SDA input synchronizer. The slave changes SDA long before the sample
  // quarter, so two cycles of latency do no harm.
  always_ff @(posedge clk) begin
    if (reset) sda_sync <= 2'b11;
    else       sda_sync <= {sda_sync[0], i2c_sdat};
  end

  always_comb begin
    cur_word = table_word(word_idx);
    unique case (byte_idx)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = cur_word[15:8];
      default: cur_byte = cur_word[7:0];
    endcase
  end

  // Next-state logic. Each case applies the action for (state, phase) on a
  // qtick. phase wraps naturally from 3 to 0.
  always_comb begin
    state_n   = state;
    phase_n   = phase + 2'd1;
    bitcnt_n  = bitcnt;
    byte_n    = byte_idx;
    word_n    = word_idx;
    wait_n    = wait_cnt;
    sclk_n    = sclk_q;
    sda_low_n = sda_low_q;
    ack_err_n = ack_error_q;
`ifdef I2C_RETRY_EN
    nack_n    = nack_q;
    retry_n   = retry_cnt;
`endif
    unique case (state)
      S_WAIT: begin
        phase_n   = 2'd0;
        sclk_n    = 1'b1;
        sda_low_n = 1'b0;
        if (wait_cnt + 16'd1 >= INIT_DELAY) begin
          state_n = S_START;
          wait_n  = 16'd0;
        end else begin
          wait_n  = wait_cnt + 16'd1;
        end
      end
      S_START: begin
        unique case (phase)
          2'd0:    begin sclk_n = 1'b1; sda_low_n = 1'b0; end
          2'd1:    sda_low_n = 1'b1;
          default: begin
            sclk_n   = 1'b0;
            state_n  = S_BIT;
            phase_n  = 2'd0;
            bitcnt_n = 3'd7;
            byte_n   = 2'd0;
`ifdef I2C_RETRY_EN
            nack_n   = 1'b0;
`endif
          end
        endcase
      end
      S_BIT: begin
        unique case (phase)
          2'd0: sda_low_n = ~cur_byte[bitcnt];
          2'd1: sclk_n = 1'b1;
          2'd2: ;
          default: begin
            sclk_n = 1'b0;
            if (bitcnt == 3'd0) state_n = S_ACK;
            else                bitcnt_n = bitcnt - 3'd1;
          end
        endcase
      end
      S_ACK: begin
        unique case (phase)
          2'd0: sda_low_n = 1'b0;
          2'd1: sclk_n = 1'b1;
          2'd2: begin
            if (sda_sync[1]) begin
`ifdef I2C_RETRY_EN
              nack_n    = 1'b1;
`else
              ack_err_n = 1'b1;
`endif
            end
          end
          default: begin
            sclk_n   = 1'b0;
            bitcnt_n = 3'd7;
`ifdef I2C_RETRY_EN
            // A NACK abandons the rest of the frame. Only the final
            // attempt reports the error.
            if (nack_q) begin
              state_n = S_STOP;
              if (retry_cnt == 2'd3) ack_err_n = 1'b1;
            end else
`endif
            if (byte_idx == 2'd2) begin
              state_n = S_STOP;
            end else begin
              state_n = S_BIT;
              byte_n  = byte_idx + 2'd1;
            end
          end
        endcase
      end
      S_STOP: begin
        unique case (phase)
          2'd0:    sda_low_n = 1'b1;
          2'd1:    sclk_n = 1'b1;
          default: begin
            sda_low_n = 1'b0;
            state_n   = S_GAP;
            phase_n   = 2'd0;
          end
        endcase
      end
      S_GAP: begin
        sclk_n    = 1'b1;
        sda_low_n = 1'b0;
        if (phase == 2'd3) begin
`ifdef I2C_RETRY_EN
          if (nack_q && retry_cnt != 2'd3) begin
            retry_n = retry_cnt + 2'd1;
            state_n = S_START;
          end else begin
            retry_n = 2'd0;
`endif
            if (word_idx == 4'd9) begin
              state_n = S_DONE;
            end else begin
              word_n  = word_idx + 4'd1;
              state_n = S_START;
            end
`ifdef I2C_RETRY_EN
          end
`endif
        end
      end
      default: begin
        phase_n   = 2'd0;
        sclk_n    = 1'b1;
        sda_low_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT;
      phase       <= 2'd0;
      bitcnt      <= 3'd7;
      byte_idx    <= 2'd0;
      word_idx    <= 4'd0;
      wait_cnt    <= 16'd0;
      sclk_q      <= 1'b1;
      sda_low_q   <= 1'b0;
      ack_error_q <= 1'b0;
`ifdef I2C_RETRY_EN
      nack_q      <= 1'b0;
      retry_cnt   <= 2'd0;
`endif
    end else if (qtick) begin
      state       <= state_n;
      phase       <= phase_n;
      bitcnt      <= bitcnt_n;
      byte_idx    <= byte_n;
      word_idx    <= word_n;
      wait_cnt    <= wait_n;
      sclk_q      <= sclk_n;
      sda_low_q   <= sda_low_n;
      ack_error_q <= ack_err_n;
`ifdef I2C_RETRY_EN
      nack_q      <= nack_n;
      retry_cnt   <= retry_n;
`endif
    end
  end

  assign i2c_sdat      = sda_low_q ? 1'b0 : 1'bz;
  assign bus.i2c_sclk  = sclk_q;
  assign bus.busy      = (state != S_DONE);
  assign bus.done      = (state == S_DONE);
  assign bus.ack_error = ack_error_q;
  assign bus.word_idx  = word_idx;
  assign bus.state_dbg = state;
endmodule
